// File: rtl/multi_ball_controller_pkg.sv
// Shared fixed-point types, edge indices, sequencer states and saturation helpers
// for the multi-ball physics controller.
package multi_ball_controller_pkg;

    typedef logic signed [31:0] fixed_t;

    localparam int unsigned EdgeLeft   = 3;
    localparam int unsigned EdgeTop    = 2;
    localparam int unsigned EdgeRight  = 1;
    localparam int unsigned EdgeBottom = 0;

    typedef enum logic [1:0] {StIdle, StUpdate, StDone} seq_state_e;

    // Sign-extend to 34 bits so a speed plus a full-range impulse cannot overflow before clamping
    function automatic logic signed [33:0] widen(input fixed_t v);
        return {{2{v[31]}}, v};
    endfunction

    function automatic fixed_t sat_clamp(input logic signed [33:0] val, input int max_speed);
        logic signed [33:0] lim;
        logic signed [33:0] neg_lim;
        lim     = 34'(max_speed);
        neg_lim = -lim;
        if (val > lim) begin
            return lim[31:0];
        end else if (val < neg_lim) begin
            return neg_lim[31:0];
        end
        return val[31:0];
    endfunction

    function automatic fixed_t init_raw(input int pix, input int frac);
        return fixed_t'(pix) <<< frac;
    endfunction

endpackage

// File: rtl/multi_ball_controller_if.sv
// Collision event bus from the hit-detection logic into the ball controller.
interface multi_ball_controller_if
    import multi_ball_controller_pkg::*;
#(
    parameter int unsigned NUM_BALLS = 4
) ();
    localparam int unsigned BW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

    logic          colValid;
    logic [BW-1:0] colBall;
    logic [3:0]    colEdge;
    fixed_t        colImpulseX;
    fixed_t        colImpulseY;

    modport master (output colValid, colBall, colEdge, colImpulseX, colImpulseY);
    modport slave  (input  colValid, colBall, colEdge, colImpulseX, colImpulseY);
endinterface

// File: rtl/multi_ball_controller_axis.sv
// One axis of the per-ball update: reflect with damping, add impulse, clamp,
// and optionally apply gravity to the stored speed.
module multi_ball_controller_axis
    import multi_ball_controller_pkg::*;
#(
    parameter int DAMP_SHIFT = 0,
    parameter int MAX_SPEED  = 1024,
    parameter int GRAVITY    = 1
) (
    input  fixed_t vel,
    input  fixed_t imp,
    input  logic   lo_hit,
    input  logic   hi_hit,
    input  logic   grav_en,
    output fixed_t step,
    output fixed_t vel_next
);
    logic               reflect;
    fixed_t             damped;
    fixed_t             v1;
    logic signed [33:0] sum;
    logic signed [33:0] fall;

    always_comb begin
        reflect  = (lo_hit && vel < 0) || (hi_hit && vel > 0);
        // A zero shift means no bounce loss rather than a zeroed speed
        damped   = (DAMP_SHIFT == 0) ? vel : vel - (vel >>> DAMP_SHIFT);
        v1       = reflect ? -damped : vel;
        sum      = widen(v1) + widen(imp);
        step     = sat_clamp(sum, MAX_SPEED);
        fall     = widen(step) + 34'(GRAVITY);
        vel_next = grav_en ? sat_clamp(fall, MAX_SPEED) : step;
    end
endmodule

// File: rtl/multi_ball_controller.sv
// Per-frame physics sequencer for NUM_BALLS balls: collects collision events during
// the frame and updates one ball per clock through a shared datapath.
module multi_ball_controller
    import multi_ball_controller_pkg::*;
#(
    parameter int NUM_BALLS    = 4,
    parameter int FRAC_BITS    = 6,
    parameter int GRAVITY      = 1,
    parameter int MAX_SPEED    = 1024,
    parameter int DAMP_SHIFT   = 0,
    parameter int INIT_X       = 300,
    parameter int INIT_Y       = 50,
    parameter int BALL_SPACING = 40
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   pause,
    input  logic                   reset_level,
    input  logic [NUM_BALLS-1:0]   ballEnable,
    multi_ball_controller_if.slave col,
    output logic [NUM_BALLS*11-1:0] topLeftX,
    output logic [NUM_BALLS*11-1:0] topLeftY,
    output logic                   busy,
    output logic                   frameDone,
    output logic                   frameOverrun
);
    localparam int unsigned KW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

    fixed_t     pos_x_q [NUM_BALLS];
    fixed_t     pos_y_q [NUM_BALLS];
    fixed_t     vel_x_q [NUM_BALLS];
    fixed_t     vel_y_q [NUM_BALLS];
    fixed_t     imp_x_q [NUM_BALLS];
    fixed_t     imp_y_q [NUM_BALLS];
    logic [3:0] edge_q  [NUM_BALLS];

    seq_state_e      state_q;
    logic [KW-1:0]   k_q;
    logic [NUM_BALLS-1:0] ev_hit;

    fixed_t     cur_vx, cur_vy, cur_ix, cur_iy;
    logic [3:0] cur_edge;
    fixed_t     step_x, step_y, vx_next, vy_next;

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
        assign ev_hit[g] = col.colValid && ballEnable[g] && (col.colBall == KW'(g));
        assign topLeftX[11*g +: 11] = pos_x_q[g][FRAC_BITS +: 11];
        assign topLeftY[11*g +: 11] = pos_y_q[g][FRAC_BITS +: 11];
    end

    always_comb begin
        cur_vx   = vel_x_q[k_q];
        cur_vy   = vel_y_q[k_q];
        cur_ix   = imp_x_q[k_q];
        cur_iy   = imp_y_q[k_q];
        cur_edge = edge_q[k_q];
    end

    multi_ball_controller_axis #(
        .DAMP_SHIFT(DAMP_SHIFT), .MAX_SPEED(MAX_SPEED), .GRAVITY(GRAVITY)
    ) u_axis_x (
        .vel(cur_vx), .imp(cur_ix), .lo_hit(cur_edge[EdgeLeft]), .hi_hit(cur_edge[EdgeRight]),
        .grav_en(1'b0), .step(step_x), .vel_next(vx_next)
    );

    multi_ball_controller_axis #(
        .DAMP_SHIFT(DAMP_SHIFT), .MAX_SPEED(MAX_SPEED), .GRAVITY(GRAVITY)
    ) u_axis_y (
        .vel(cur_vy), .imp(cur_iy), .lo_hit(cur_edge[EdgeTop]), .hi_hit(cur_edge[EdgeBottom]),
        .grav_en(1'b1), .step(step_y), .vel_next(vy_next)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int b = 0; b < NUM_BALLS; b++) begin
                pos_x_q[b] <= init_raw(INIT_X + b * BALL_SPACING, FRAC_BITS);
                pos_y_q[b] <= init_raw(INIT_Y, FRAC_BITS);
                vel_x_q[b] <= '0;
                vel_y_q[b] <= '0;
                imp_x_q[b] <= '0;
                imp_y_q[b] <= '0;
                edge_q[b]  <= '0;
            end
            state_q      <= StIdle;
            k_q          <= '0;
            busy         <= 1'b0;
            frameDone    <= 1'b0;
            frameOverrun <= 1'b0;
        end else if (reset_level) begin
            for (int b = 0; b < NUM_BALLS; b++) begin
                pos_x_q[b] <= init_raw(INIT_X + b * BALL_SPACING, FRAC_BITS);
                pos_y_q[b] <= init_raw(INIT_Y, FRAC_BITS);
                vel_x_q[b] <= '0;
                vel_y_q[b] <= '0;
                imp_x_q[b] <= '0;
                imp_y_q[b] <= '0;
                edge_q[b]  <= '0;
            end
            state_q      <= StIdle;
            k_q          <= '0;
            busy         <= 1'b0;
            frameDone    <= 1'b0;
            frameOverrun <= 1'b0;
        end else if (!pause) begin
            frameDone <= 1'b0;
            for (int b = 0; b < NUM_BALLS; b++) begin
                if (state_q == StUpdate && k_q == KW'(b)) begin
                    if (ballEnable[b]) begin
                        pos_x_q[b] <= pos_x_q[b] + step_x;
                        pos_y_q[b] <= pos_y_q[b] + step_y;
                        vel_x_q[b] <= vx_next;
                        vel_y_q[b] <= vy_next;
                    end
                    // An event landing on the ball being updated seeds next frame's pending
                    edge_q[b]  <= ev_hit[b] ? col.colEdge : 4'b0;
                    imp_x_q[b] <= ev_hit[b] ? col.colImpulseX : '0;
                    imp_y_q[b] <= ev_hit[b] ? col.colImpulseY : '0;
                end else if (ev_hit[b]) begin
                    edge_q[b]  <= edge_q[b] | col.colEdge;
                    imp_x_q[b] <= imp_x_q[b] + col.colImpulseX;
                    imp_y_q[b] <= imp_y_q[b] + col.colImpulseY;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (startOfFrame) begin
                        state_q <= StUpdate;
                        k_q     <= '0;
                        busy    <= 1'b1;
                    end
                end
                StUpdate: begin
                    if (startOfFrame) frameOverrun <= 1'b1;
                    if (k_q == KW'(NUM_BALLS - 1)) begin
                        state_q   <= StDone;
                        frameDone <= 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                StDone: begin
                    if (startOfFrame) frameOverrun <= 1'b1;
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
